// File: rtl/cmd_registry_pkg.sv
// Shared types and constants for the command registry feeder.
//  cmd_t     : one pulse-burst command, field-for-field with the MEM_* outputs (338 bits)
//  state_t   : delivery FSM states
//  staging_t : the eleven 32-bit host words of the staging register
//  words_to_cmd() unpacks the host word map into a cmd_t.
package cmd_registry_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 11;

  // Host word map
  localparam int W_FREQ_LO    = 0;   // freq[31:0]
  localparam int W_FREQ_HI_DF = 1;   // {delta_freq[15:0], freq[47:32]}
  localparam int W_DF_HI      = 2;   // delta_freq[47:16]
  localparam int W_RATE       = 3;   // delta_rate
  localparam int W_TS_LO      = 4;   // time_start[31:0]
  localparam int W_TS_HI      = 5;   // time_start[63:32]
  localparam int W_N_TYPE     = 6;   // {14'b0, type[1:0], n_impuls[15:0]}
  localparam int W_TI         = 7;
  localparam int W_TP         = 8;
  localparam int W_TBLANK1    = 9;
  localparam int W_TBLANK2    = 10;

  typedef struct packed {
    logic [47:0] dds_freq;
    logic [47:0] dds_delta_freq;
    logic [31:0] dds_delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_CHECK
  } state_t;

  typedef logic [N_WORDS-1:0][WORD_W-1:0] staging_t;

  function automatic cmd_t words_to_cmd(input staging_t w);
    cmd_t c;
    c.dds_freq       = {w[W_FREQ_HI_DF][15:0], w[W_FREQ_LO]};
    c.dds_delta_freq = {w[W_DF_HI], w[W_FREQ_HI_DF][31:16]};
    c.dds_delta_rate = w[W_RATE];
    c.time_start     = {w[W_TS_HI], w[W_TS_LO]};
    c.n_impuls       = w[W_N_TYPE][15:0];
    c.type_impulse   = w[W_N_TYPE][17:16];
    c.interval_ti    = w[W_TI];
    c.interval_tp    = w[W_TP];
    c.tblank1        = w[W_TBLANK1];
    c.tblank2        = w[W_TBLANK2];
    return c;
  endfunction

endpackage

// File: rtl/cmd_registry_feeder_if.sv
// Host / master side bundle of the command registry feeder.
//  master modport : the environment (host CPU + pulse-burst master) view
//  slave modport  : the feeder view
//  Host staging writes, commit, flush and flag clear; the master's request level,
//  system time and sync flag; the load strobe, delivered MEM_* fields and FIFO status.
interface cmd_registry_feeder_if #(
  parameter int DEPTH = 16
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          host_wr;
  logic [3:0]    host_addr;
  logic [31:0]   host_data;
  logic          host_commit;
  logic          flush;
  logic          clr_flags;
  logic          req_command;
  logic [63:0]   sys_time;
  logic          sys_time_update_ok;

  logic          wr_data;
  logic [47:0]   mem_dds_freq;
  logic [47:0]   mem_dds_delta_freq;
  logic [31:0]   mem_dds_delta_rate;
  logic [63:0]   mem_time_start;
  logic [15:0]   mem_n_impuls;
  logic [1:0]    mem_type_impulse;
  logic [31:0]   mem_interval_ti;
  logic [31:0]   mem_interval_tp;
  logic [31:0]   mem_tblank1;
  logic [31:0]   mem_tblank2;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
  logic [15:0]   stale_cnt;

  modport master (
    output host_wr, host_addr, host_data, host_commit, flush, clr_flags,
           req_command, sys_time, sys_time_update_ok,
    input  wr_data, mem_dds_freq, mem_dds_delta_freq, mem_dds_delta_rate,
           mem_time_start, mem_n_impuls, mem_type_impulse, mem_interval_ti,
           mem_interval_tp, mem_tblank1, mem_tblank2, fifo_level, fifo_empty,
           fifo_full, overflow, stale_cnt
  );

  modport slave (
    input  host_wr, host_addr, host_data, host_commit, flush, clr_flags,
           req_command, sys_time, sys_time_update_ok,
    output wr_data, mem_dds_freq, mem_dds_delta_freq, mem_dds_delta_rate,
           mem_time_start, mem_n_impuls, mem_type_impulse, mem_interval_ti,
           mem_interval_tp, mem_tblank1, mem_tblank2, fifo_level, fifo_empty,
           fifo_full, overflow, stale_cnt
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered read data.
//  clk, reset     : clock, synchronous active-high reset
//  flush          : empty the FIFO (wins over push and pop)
//  push/push_data : write when not full; ignored when full
//  pop/pop_data   : read when not empty; pop_data is valid the cycle after pop
//  level/full/empty : occupancy before this cycle's push/pop
module cmd_fifo
  import cmd_registry_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = cmd_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // NOTE: storage and its read register carry no reset so they map onto block
  // RAM; only pointers and count need a known state, and empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_pop)  pop_data    <= mem[rd_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_registry_feeder.sv
// Real-time command registry feeding the pulse-burst master.
//  clk, reset : 48 MHz clock, synchronous active-high reset
//  bus        : host staging/commit/flush/clear, master request/time inputs,
//               WR_DATA strobe, MEM_* command fields, FIFO status, overflow, stale count
// The host fills an eleven-word staging register and commits it into the FIFO.
// One command is preloaded after reset/flush; afterwards one is delivered per
// rising edge of req_command. Commands whose start time is too close or past
// are dropped and counted instead of delivered.
module cmd_registry_feeder
  import cmd_registry_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int GUARD_TICKS = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  cmd_registry_feeder_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  staging_t         staging;
  cmd_t             staged_cmd;
  cmd_t             fifo_rd;
  cmd_t             mem_q;
  cmd_t             mem_out;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             overflow_set;

  state_t           state;
  state_t           state_next;
  logic             req_d;
  logic             req_edge;
  logic             pend;
  logic             loaded;
  logic             stale;
  logic             deliver;
  logic             stale_drop;
  logic             overflow;
  logic [15:0]      stale_cnt;
  logic [15:0]      stale_base;

  // ---------------- staging register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      staging <= '0;
    end else begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (bus.host_wr && bus.host_addr == 4'(i)) staging[i] <= bus.host_data;
      end
    end
  end

  // Commit pushes the registered staging value, i.e. before any same-cycle write.
  assign staged_cmd   = words_to_cmd(staging);
  assign fifo_push    = bus.host_commit & ~bus.flush;
  assign overflow_set = bus.host_commit & ~bus.flush & full;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .push      (fifo_push),
    .push_data (staged_cmd),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // ---------------- request edge and delivery FSM ----------------
  assign req_edge = bus.req_command & ~req_d;

  // The add wraps at 64 bits, so a time near the top of the range makes the
  // guard window wrap too; this matches the master's own time arithmetic.
  assign stale = bus.sys_time_update_ok &
                 (fifo_rd.time_start <= bus.sys_time + 64'(GUARD_TICKS));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path through the
  // case leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    deliver    = 1'b0;
    stale_drop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && (!loaded || pend)) state_next = S_POP;
      end
      S_POP: begin
        fifo_pop   = 1'b1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = S_IDLE;
        if (stale) stale_drop = 1'b1;
        else       deliver    = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // Flush aborts whatever is in flight, including a delivery this cycle.
    if (bus.flush) begin
      state_next = S_IDLE;
      fifo_pop   = 1'b0;
      deliver    = 1'b0;
      stale_drop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_d  <= 1'b0;
      pend   <= 1'b0;
      loaded <= 1'b0;
      mem_q  <= '0;
    end else begin
      req_d <= bus.req_command;
      if (bus.flush) begin
        pend   <= 1'b0;
        loaded <= 1'b0;
      end else begin
        // A new edge arriving on the delivery cycle is a fresh request.
        pend <= req_edge | (pend & ~deliver);
        if (deliver) loaded <= 1'b1;
      end
      if (deliver) mem_q <= fifo_rd;
    end
  end

  // The strobe and the data it qualifies must be valid in the same cycle, so
  // the delivering cycle bypasses the holding register.
  assign mem_out = deliver ? fifo_rd : mem_q;

  // ---------------- flags ----------------
  // A same-cycle clear is applied first so the set event still lands.
  assign stale_base = bus.clr_flags ? 16'h0000 : stale_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      stale_cnt <= '0;
    end else begin
      if (overflow_set)       overflow <= 1'b1;
      else if (bus.clr_flags) overflow <= 1'b0;
      if (stale_drop && stale_base != 16'hFFFF) stale_cnt <= stale_base + 16'd1;
      else                                      stale_cnt <= stale_base;
    end
  end

  // ---------------- outputs ----------------
  assign bus.wr_data            = deliver;
  assign bus.mem_dds_freq       = mem_out.dds_freq;
  assign bus.mem_dds_delta_freq = mem_out.dds_delta_freq;
  assign bus.mem_dds_delta_rate = mem_out.dds_delta_rate;
  assign bus.mem_time_start     = mem_out.time_start;
  assign bus.mem_n_impuls       = mem_out.n_impuls;
  assign bus.mem_type_impulse   = mem_out.type_impulse;
  assign bus.mem_interval_ti    = mem_out.interval_ti;
  assign bus.mem_interval_tp    = mem_out.interval_tp;
  assign bus.mem_tblank1        = mem_out.tblank1;
  assign bus.mem_tblank2        = mem_out.tblank2;
  assign bus.fifo_level         = level;
  assign bus.fifo_empty         = empty;
  assign bus.fifo_full          = full;
  assign bus.overflow           = overflow;
  assign bus.stale_cnt          = stale_cnt;

endmodule

// File: tb/tb_cmd_registry_feeder.sv
// Directed, self-checking bench for cmd_registry_feeder.
module tb_cmd_registry_feeder;
  import cmd_registry_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_registry_feeder_if #(.DEPTH(DEPTH)) bus();

  cmd_registry_feeder #(
    .DEPTH       (DEPTH),
    .GUARD_TICKS (48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  always @(negedge clk) if (bus.wr_data === 1'b1) wr_count++;

  typedef struct {
    logic [63:0] t;
    logic        ok;
    logic [63:0] ts;
    logic        deliver;
  } vec_t;

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cmd(input string name, input cmd_t got, input cmd_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic cmd_t mem_now();
    cmd_t c;
    c.dds_freq       = bus.mem_dds_freq;
    c.dds_delta_freq = bus.mem_dds_delta_freq;
    c.dds_delta_rate = bus.mem_dds_delta_rate;
    c.time_start     = bus.mem_time_start;
    c.n_impuls       = bus.mem_n_impuls;
    c.type_impulse   = bus.mem_type_impulse;
    c.interval_ti    = bus.mem_interval_ti;
    c.interval_tp    = bus.mem_interval_tp;
    c.tblank1        = bus.mem_tblank1;
    c.tblank2        = bus.mem_tblank2;
    return c;
  endfunction

  function automatic cmd_t mk_cmd(input logic [47:0] freq, input logic [63:0] ts,
                                  input logic [15:0] n, input logic [31:0] tag);
    cmd_t c;
    c.dds_freq       = freq;
    c.dds_delta_freq = {tag[15:0], tag};
    c.dds_delta_rate = ~tag;
    c.time_start     = ts;
    c.n_impuls       = n;
    c.type_impulse   = tag[1:0];
    c.interval_ti    = tag + 32'd1;
    c.interval_tp    = tag + 32'd2;
    c.tblank1        = tag + 32'd3;
    c.tblank2        = tag + 32'd4;
    return c;
  endfunction

  // Writes the eleven host words straight from the documented word map,
  // then pokes an out-of-range address that must be ignored.
  task automatic write_cmd(input cmd_t c);
    logic [31:0] w [11];
    w[0]  = c.dds_freq[31:0];
    w[1]  = {c.dds_delta_freq[15:0], c.dds_freq[47:32]};
    w[2]  = c.dds_delta_freq[47:16];
    w[3]  = c.dds_delta_rate;
    w[4]  = c.time_start[31:0];
    w[5]  = c.time_start[63:32];
    w[6]  = {14'b0, c.type_impulse, c.n_impuls};
    w[7]  = c.interval_ti;
    w[8]  = c.interval_tp;
    w[9]  = c.tblank1;
    w[10] = c.tblank2;
    for (int i = 0; i < 12; i++) begin
      bus.host_wr   = 1'b1;
      bus.host_addr = 4'(i);
      bus.host_data = (i < 11) ? w[i] : 32'hDEAD_BEEF;
      tick();
    end
    bus.host_wr = 1'b0;
  endtask

  task automatic commit();
    bus.host_commit = 1'b1;
    tick();
    bus.host_commit = 1'b0;
  endtask

  // Returns the cycle (commit cycle = 0) in which wr_data was seen, or 0 if none.
  task automatic commit_wait(input int budget, output int lat);
    commit();
    lat = 1;
    while (!bus.wr_data && lat < budget) begin
      tick();
      lat++;
    end
    if (!bus.wr_data) lat = 0;
  endtask

  task automatic wait_wr(input int budget, output logic found);
    int n;
    n = 0;
    while (!bus.wr_data && n < budget) begin
      tick();
      n++;
    end
    found = bus.wr_data;
  endtask

  task automatic req_pulse();
    bus.req_command = 1'b1;
    tick();
    bus.req_command = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, " wr_data"},    64'(bus.wr_data),    64'd0);
    check_cmd({pfx, " mem"},    mem_now(),           '0);
    check({pfx, " level"},      64'(bus.fifo_level), 64'd0);
    check({pfx, " empty"},      64'(bus.fifo_empty), 64'd1);
    check({pfx, " full"},       64'(bus.fifo_full),  64'd0);
    check({pfx, " overflow"},   64'(bus.overflow),   64'd0);
    check({pfx, " stale_cnt"},  64'(bus.stale_cnt),  64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t  vecs [7];
    cmd_t  a, b, c, d, e, f, g, p, last;
    cmd_t  q [DEPTH+1];
    int    lat;
    int    snap;
    int    exp_stale;
    logic  found;

    // Stale comparator vectors: time, sync flag, start time, expect delivery.
    vecs[0] = '{64'd1000, 1'b1, 64'd1048, 1'b0};                  // exactly at guard
    vecs[1] = '{64'd1000, 1'b1, 64'd1049, 1'b1};                  // one tick beyond guard
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h20, 1'b0};     // guard wraps, at limit
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h21, 1'b1};     // guard wraps, beyond
    vecs[4] = '{64'd5000, 1'b0, 64'd0,    1'b1};                  // unsynchronised time
    vecs[5] = '{64'd5000, 1'b1, 64'd4999, 1'b0};                  // start already past
    vecs[6] = '{64'd0,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};   // far future

    reset                  = 1'b1;
    bus.host_wr            = 1'b0;
    bus.host_addr          = '0;
    bus.host_data          = '0;
    bus.host_commit        = 1'b0;
    bus.flush              = 1'b0;
    bus.clr_flags          = 1'b0;
    bus.req_command        = 1'b0;
    bus.sys_time           = '0;
    bus.sys_time_update_ok = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // 1: preload after reset
    a = mk_cmd(48'h1234_5678_9ABC, 64'd1000, 16'd3, 32'hA000_0001);
    write_cmd(a);
    commit_wait(6, lat);
    check("t1 latency", 64'(lat), 64'd3);
    check_cmd("t1 mem", mem_now(), a);
    tick();
    check("t1 strobe one cycle", 64'(bus.wr_data), 64'd0);
    check("t1 level", 64'(bus.fifo_level), 64'd0);
    check_cmd("t1 mem hold", mem_now(), a);

    // 2: one delivery per rising edge, level held high
    b = mk_cmd(48'hB, 64'd2000, 16'd4, 32'hB000_0002);
    c = mk_cmd(48'hC, 64'd3000, 16'd5, 32'hC000_0003);
    snap = wr_count;
    write_cmd(b);
    commit();
    write_cmd(c);
    commit();
    tick();
    check("t2 no delivery without request", 64'(wr_count - snap), 64'd0);
    check("t2 level 2", 64'(bus.fifo_level), 64'd2);
    bus.req_command = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("t2 one strobe", 64'(wr_count - snap), 64'd1);
    check("t2 level 1", 64'(bus.fifo_level), 64'd1);
    check_cmd("t2 mem B", mem_now(), b);
    bus.req_command = 1'b0;
    tick();

    // 3: deliver C, then a stale D is dropped, then D is delivered unsynchronised
    req_pulse();
    wait_wr(8, found);
    check("t3 C delivered", 64'(found), 64'd1);
    check_cmd("t3 mem C", mem_now(), c);
    tick();
    bus.sys_time = 64'd5000;
    d = mk_cmd(48'hD, 64'd5010, 16'd6, 32'hD000_0004);
    write_cmd(d);
    commit();
    snap = wr_count;
    req_pulse();
    for (int i = 0; i < 8; i++) tick();
    check("t3 stale no strobe", 64'(wr_count - snap), 64'd0);
    check("t3 stale_cnt", 64'(bus.stale_cnt), 64'd1);
    check_cmd("t3 mem unchanged", mem_now(), c);
    check("t3 level", 64'(bus.fifo_level), 64'd0);
    bus.sys_time_update_ok = 1'b0;
    write_cmd(d);
    commit_wait(6, lat);
    check("t3 D latency", 64'(lat), 64'd3);
    check_cmd("t3 mem D", mem_now(), d);
    tick();

    // 4: request on empty FIFO stays pending until the next commit
    bus.sys_time_update_ok = 1'b1;
    e = mk_cmd(48'hE, 64'd100000, 16'd7, 32'hE000_0005);
    snap = wr_count;
    req_pulse();
    for (int i = 0; i < 20; i++) tick();
    check("t4 no strobe while empty", 64'(wr_count - snap), 64'd0);
    write_cmd(e);
    commit_wait(6, lat);
    check("t4 latency", 64'(lat), 64'd3);
    check_cmd("t4 mem E", mem_now(), e);
    tick();

    // Table: stale comparator boundaries
    last      = e;
    exp_stale = 1;
    for (int i = 0; i < 7; i++) begin
      cmd_t v;
      v = mk_cmd(48'hA0_0000_0000 + 48'(i), vecs[i].ts, 16'(i), 32'h100 + 32'(i));
      bus.sys_time           = vecs[i].t;
      bus.sys_time_update_ok = vecs[i].ok;
      req_pulse();
      write_cmd(v);
      commit_wait(6, lat);
      if (vecs[i].deliver) begin
        check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
        last = v;
      end else begin
        check($sformatf("vec%0d dropped", i), 64'(lat), 64'd0);
        exp_stale++;
      end
      check_cmd($sformatf("vec%0d mem", i), mem_now(), last);
      tick();
      check($sformatf("vec%0d stale_cnt", i), 64'(bus.stale_cnt), 64'(exp_stale));
    end

    // Reset in the middle of a delivery
    bus.sys_time           = '0;
    bus.sys_time_update_ok = 1'b1;
    req_pulse();
    write_cmd(mk_cmd(48'h77, 64'd9000, 16'd1, 32'h77));
    commit();
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("mid reset");
    reset = 1'b0;
    snap  = wr_count;
    for (int i = 0; i < 6; i++) tick();
    check("mid reset no strobe", 64'(wr_count - snap), 64'd0);

    // 5: overflow with DEPTH+1 commits
    p = mk_cmd(48'h50, 64'd1000, 16'd9, 32'h5000_0000);
    write_cmd(p);
    commit_wait(6, lat);
    check("t5 preload latency", 64'(lat), 64'd3);
    tick();
    for (int i = 0; i <= DEPTH; i++) begin
      q[i] = mk_cmd(48'h5100 + 48'(i), 64'd2000 + 64'(i), 16'(i), 32'h5100 + 32'(i));
      write_cmd(q[i]);
      if (i == DEPTH) begin
        check("t5 full before last", 64'(bus.fifo_full), 64'd1);
        check("t5 no overflow yet", 64'(bus.overflow), 64'd0);
      end
      commit();
    end
    check("t5 overflow", 64'(bus.overflow), 64'd1);
    check("t5 level", 64'(bus.fifo_level), 64'(DEPTH));
    bus.host_commit = 1'b1;
    bus.clr_flags   = 1'b1;
    tick();
    bus.host_commit = 1'b0;
    bus.clr_flags   = 1'b0;
    check("t5 set beats clear", 64'(bus.overflow), 64'd1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    check("t5 overflow cleared", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      req_pulse();
      wait_wr(8, found);
      check($sformatf("t5 drain %0d", i), 64'(found), 64'd1);
      tick();
    end
    check_cmd("t5 last kept is entry 15", mem_now(), q[DEPTH-1]);
    check("t5 drained", 64'(bus.fifo_empty), 64'd1);

    // 6: flush during the delivering cycle
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    f = mk_cmd(48'hF, 64'd100000, 16'd10, 32'hF000_0006);
    write_cmd(f);
    commit();
    tick();
    tick();
    check("t6 in delivery cycle", 64'(bus.wr_data), 64'd1);
    bus.flush = 1'b1;
    #1;
    check("t6 flush suppresses strobe", 64'(bus.wr_data), 64'd0);
    check_cmd("t6 mem not F", mem_now(), q[DEPTH-1]);
    tick();
    bus.flush = 1'b0;
    check("t6 empty", 64'(bus.fifo_empty), 64'd1);
    snap = wr_count;
    for (int i = 0; i < 6; i++) tick();
    check("t6 no late strobe", 64'(wr_count - snap), 64'd0);
    check_cmd("t6 mem held", mem_now(), q[DEPTH-1]);
    g = mk_cmd(48'h6, 64'd200000, 16'd11, 32'h6000_0007);
    write_cmd(g);
    commit_wait(6, lat);
    check("t6 G preload latency", 64'(lat), 64'd3);
    check_cmd("t6 mem G", mem_now(), g);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
